// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states and counter sizing.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_e;

  // Timeout / gap counter width; counters saturate at all-ones.
  localparam int unsigned CNT_W = 8;
  // Requester index width (up to 8 requesters).
  localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/uart_xmit_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [7:0]       req_pad;
  logic [IDX_W-1:0] cand;

  // Search ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the first hit wins.
  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req;
    cand  = '0;
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any && req_pad[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      grant[j] = any && (idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/uart_xmit_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources with round-robin
// arbitration and packet lock (grant held until the owner's last byte).
module uart_xmit_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned START_TO   = 8,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                 sysclk,
  input  logic                 sysrstH,
  input  logic [NUM_REQ-1:0]   reqH,
  input  logic [8*NUM_REQ-1:0] reqdataH,
  input  logic [NUM_REQ-1:0]   reqlastH,
  output logic [NUM_REQ-1:0]   ackH,
  output logic                 xmitH,
  output logic [7:0]           xmitdataH,
  input  logic                 xmitdoneH,
  output logic                 busyH,
  output logic [2:0]           curReqH,
  output logic                 errH
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  arb_state_e state, state_n;

  logic [CNT_W-1:0]   cnt;
  logic               lock;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur;
  logic               xmit_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [7:0]         data_q;
  logic               err_q;

  logic [NUM_REQ-1:0] rr_grant;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_any;

  logic [NUM_REQ-1:0] cur_mask;
  logic [NUM_REQ-1:0] win_mask;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               win_last;
  logic [7:0]         win_data;
  logic               lock_hit;

  logic launch;
  logic cnt_clr;
  logic cnt_inc;
  logic set_err;
  logic lock_clr;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req   (reqH),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Winner selection: a locked owner that still requests beats round-robin.
  always_comb begin
    cur_mask = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      cur_mask[j] = (cur == IDX_W'(j));
    end
    lock_hit = lock && |(reqH & cur_mask);
    win_mask = lock_hit ? cur_mask : rr_grant;
    win_idx  = lock_hit ? cur : rr_idx;
    win_any  = lock_hit || rr_any;
    win_data = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (win_mask[j]) begin
        win_data = reqdataH[8*j +: 8];
      end
    end
    win_last = |(reqlastH & win_mask);
  end

  // FSM state register.
  always_ff @(posedge sysclk or posedge sysrstH) begin
    if (sysrstH) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state and datapath control.
  always_comb begin
    state_n  = state;
    launch   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    set_err  = 1'b0;
    lock_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|reqH && xmitdoneH) begin
          state_n = ST_ARB;
        end
      end
      ST_ARB: begin
        if (win_any) begin
          launch  = 1'b1;
          cnt_clr = 1'b1;
          state_n = ST_WAIT_BUSY;
        end else begin
          lock_clr = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      ST_WAIT_BUSY: begin
        if (!xmitdoneH) begin
          state_n = ST_WAIT_DONE;
        end else if (cnt == TO_LAST) begin
          set_err  = 1'b1;
          lock_clr = 1'b1;
          state_n  = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (xmitdoneH) begin
          if (GAP_CYCLES > 0) begin
            cnt_clr = 1'b1;
            state_n = ST_GAP;
          end else begin
            state_n = ST_ARB;
          end
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = ST_ARB;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Launch registers, grant bookkeeping, sticky error and saturating counter.
  always_ff @(posedge sysclk or posedge sysrstH) begin
    if (sysrstH) begin
      xmit_q <= 1'b0;
      ack_q  <= '0;
      data_q <= '0;
      cur    <= '0;
      ptr    <= IDX_W'(NUM_REQ - 1);
      lock   <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      xmit_q <= launch;
      ack_q  <= launch ? win_mask : '0;
      if (launch) begin
        data_q <= win_data;
        cur    <= win_idx;
        ptr    <= win_idx;
        lock   <= ~win_last;
      end else if (lock_clr) begin
        lock <= 1'b0;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign xmitH     = xmit_q;
  assign ackH      = ack_q;
  assign xmitdataH = data_q;
  assign curReqH   = cur;
  assign errH      = err_q;
  assign busyH     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_xmit_arbiter.sv
// Directed bench for uart_xmit_arbiter: vector table plus multi-cycle sequences,
// with a simple transmitter model that answers each launch.
module tb_uart_xmit_arbiter;

  logic        sysclk = 1'b0;
  logic        sysrstH;
  logic [3:0]  reqH;
  logic [31:0] reqdataH;
  logic [3:0]  reqlastH;
  logic [3:0]  ackH;
  logic        xmitH;
  logic [7:0]  xmitdataH;
  logic        xmitdoneH;
  logic        busyH;
  logic [2:0]  curReqH;
  logic        errH;

  uart_xmit_arbiter #(
    .NUM_REQ   (4),
    .START_TO  (8),
    .GAP_CYCLES(4)
  ) dut (
    .sysclk    (sysclk),
    .sysrstH   (sysrstH),
    .reqH      (reqH),
    .reqdataH  (reqdataH),
    .reqlastH  (reqlastH),
    .ackH      (ackH),
    .xmitH     (xmitH),
    .xmitdataH (xmitdataH),
    .xmitdoneH (xmitdoneH),
    .busyH     (busyH),
    .curReqH   (curReqH),
    .errH      (errH)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_ack;
    logic [2:0]  exp_idx;
    logic [7:0]  exp_byte;
  } vec_t;

  localparam logic [31:0] D0 = 32'hC35A3CA5;
  localparam logic [31:0] D1 = 32'h44332211;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int busy_left = 0;
  bit stuck = 1'b0;
  logic [7:0] rx_q[$];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_cond(input string name, input logic ok, input logic [31:0] act, input string what);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s actual=%0h required=%s", name, act, what);
    end
  endtask

  // One cycle: sample at negedge, check launch/ack coincidence, advance the transmitter model.
  task automatic step();
    @(negedge sysclk);
    cyc++;
    if (xmitH || (ackH != 4'b0000)) begin
      check_cond("ack_onehot_with_xmit", xmitH && $onehot(ackH), {27'd0, xmitH, ackH},
                 "xmit=1 and onehot ack");
    end
    if (!stuck && xmitH) begin
      rx_q.push_back(xmitdataH);
      busy_left = 3;
      xmitdoneH = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        xmitdoneH = 1'b1;
        rise_cyc  = cyc;
      end
    end
  endtask

  task automatic wait_xmit(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (xmitH) begin
        ok = 1'b1;
        return;
      end
    end
    check_cond("xmit_timeout", 1'b0, 32'd0, "launch within 60 cycles");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busyH) return;
      step();
    end
    check_cond("idle_timeout", !busyH, {31'd0, busyH}, "busy low within 60 cycles");
  endtask

  vec_t vecs[15];

  initial begin
    bit ok;
    int n1;
    int delta;
    logic [2:0] exp_idx_seq[5];
    logic [7:0] exp_byte_seq[5];

    vecs[0]  = '{4'b1111, D0, 4'b0001, 3'd0, 8'hA5};
    vecs[1]  = '{4'b1111, D0, 4'b0010, 3'd1, 8'h3C};
    vecs[2]  = '{4'b1111, D0, 4'b0100, 3'd2, 8'h5A};
    vecs[3]  = '{4'b1111, D0, 4'b1000, 3'd3, 8'hC3};
    vecs[4]  = '{4'b1111, D0, 4'b0001, 3'd0, 8'hA5};
    vecs[5]  = '{4'b0001, D0, 4'b0001, 3'd0, 8'hA5};
    vecs[6]  = '{4'b0110, D1, 4'b0010, 3'd1, 8'h22};
    vecs[7]  = '{4'b0110, D1, 4'b0100, 3'd2, 8'h33};
    vecs[8]  = '{4'b1001, D0, 4'b1000, 3'd3, 8'hC3};
    vecs[9]  = '{4'b0100, D0, 4'b0100, 3'd2, 8'h5A};
    vecs[10] = '{4'b1001, D0, 4'b1000, 3'd3, 8'hC3};
    vecs[11] = '{4'b1001, D0, 4'b0001, 3'd0, 8'hA5};
    vecs[12] = '{4'b1010, D0, 4'b0010, 3'd1, 8'h3C};
    vecs[13] = '{4'b1010, D0, 4'b1000, 3'd3, 8'hC3};
    vecs[14] = '{4'b1001, D0, 4'b0001, 3'd0, 8'hA5};

    exp_idx_seq  = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd0};
    exp_byte_seq = '{8'h11, 8'h12, 8'h13, 8'h22, 8'h00};

    sysrstH   = 1'b1;
    reqH      = 4'b0000;
    reqdataH  = 32'd0;
    reqlastH  = 4'b0000;
    xmitdoneH = 1'b1;
    step();
    step();
    check_eq("rst_xmit", {31'd0, xmitH}, 32'd0);
    check_eq("rst_ack", {28'd0, ackH}, 32'd0);
    check_eq("rst_busy", {31'd0, busyH}, 32'd0);
    check_eq("rst_cur", {29'd0, curReqH}, 32'd0);
    check_eq("rst_data", {24'd0, xmitdataH}, 32'd0);
    check_eq("rst_err", {31'd0, errH}, 32'd0);
    sysrstH = 1'b0;
    step();

    // Single-byte packets: round-robin order and data routing.
    for (int v = 0; v < 15; v++) begin
      reqH     = vecs[v].req;
      reqdataH = vecs[v].data;
      reqlastH = 4'b1111;
      wait_xmit(ok);
      if (ok) begin
        check_eq($sformatf("vec%0d_ack", v), {28'd0, ackH}, {28'd0, vecs[v].exp_ack});
        check_eq($sformatf("vec%0d_cur", v), {29'd0, curReqH}, {29'd0, vecs[v].exp_idx});
        check_eq($sformatf("vec%0d_data", v), {24'd0, xmitdataH}, {24'd0, vecs[v].exp_byte});
      end
      reqH = 4'b0000;
      wait_idle();
      check_eq($sformatf("vec%0d_rx", v), (rx_q.size() > 0) ? {24'd0, rx_q[$]} : 32'hFFFF,
               {24'd0, vecs[v].exp_byte});
    end

    // Packet lock: requester 1 sends three bytes while 0 and 2 wait.
    n1       = 0;
    reqH     = 4'b0111;
    reqdataH = {8'h00, 8'h22, 8'h11, 8'h00};
    reqlastH = 4'b0101;
    for (int t = 0; t < 5; t++) begin
      wait_xmit(ok);
      if (ok) begin
        check_eq($sformatf("lock%0d_cur", t), {29'd0, curReqH}, {29'd0, exp_idx_seq[t]});
        check_eq($sformatf("lock%0d_data", t), {24'd0, xmitdataH}, {24'd0, exp_byte_seq[t]});
        if (curReqH == 3'd1 && n1 < 2) begin
          n1++;
          reqdataH[15:8] = 8'h11 + 8'(n1);
          reqlastH[1]    = (n1 == 2);
        end else begin
          reqH[curReqH[1:0]] = 1'b0;
        end
      end
    end
    reqH = 4'b0000;
    wait_idle();

    // Transmitter never goes busy: timeout raises errH and returns to IDLE.
    stuck    = 1'b1;
    reqH     = 4'b0001;
    reqdataH = D0;
    reqlastH = 4'b1111;
    wait_xmit(ok);
    reqH = 4'b0000;
    for (int i = 0; i < 7; i++) step();
    check_eq("to_err_before", {31'd0, errH}, 32'd0);
    check_eq("to_busy_before", {31'd0, busyH}, 32'd1);
    step();
    check_eq("to_err_after", {31'd0, errH}, 32'd1);
    check_eq("to_idle_after", {31'd0, busyH}, 32'd0);
    stuck = 1'b0;
    reqH  = 4'b0100;
    wait_xmit(ok);
    check_eq("post_err_cur", {29'd0, curReqH}, 32'd2);
    check_eq("post_err_sticky", {31'd0, errH}, 32'd1);
    reqH = 4'b0000;
    wait_idle();

    // Gap after each byte: two-byte packet from requester 2.
    reqH     = 4'b0100;
    reqdataH = 32'h00770000;
    reqlastH = 4'b0000;
    wait_xmit(ok);
    check_eq("gap_byte0", {24'd0, xmitdataH}, 32'h77);
    reqdataH = 32'h00780000;
    reqlastH = 4'b0100;
    wait_xmit(ok);
    delta = cyc - rise_cyc;
    check_cond("gap_delay", (delta >= 5) && (delta <= 8), 32'(delta), "5..8 cycles");
    check_eq("gap_byte1", {24'd0, xmitdataH}, 32'h78);
    reqH = 4'b0000;
    wait_idle();

    // Reset while waiting for the byte to finish.
    reqH     = 4'b1000;
    reqdataH = D0;
    reqlastH = 4'b1111;
    wait_xmit(ok);
    check_eq("pre_rst_cur", {29'd0, curReqH}, 32'd3);
    reqH = 4'b0000;
    step();
    check_eq("pre_rst_busy", {31'd0, busyH}, 32'd1);
    #2 sysrstH = 1'b1;
    #1;
    check_eq("mid_rst_xmit", {31'd0, xmitH}, 32'd0);
    check_eq("mid_rst_ack", {28'd0, ackH}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busyH}, 32'd0);
    check_eq("mid_rst_cur", {29'd0, curReqH}, 32'd0);
    check_eq("mid_rst_data", {24'd0, xmitdataH}, 32'd0);
    check_eq("mid_rst_err", {31'd0, errH}, 32'd0);
    busy_left = 0;
    xmitdoneH = 1'b1;
    step();
    sysrstH = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("no_resend", {31'd0, xmitH}, 32'd0);
    end
    reqH = 4'b1001;
    wait_xmit(ok);
    check_eq("post_rst_cur", {29'd0, curReqH}, 32'd0);
    check_eq("post_rst_ack", {28'd0, ackH}, 32'd1);
    check_eq("post_rst_data", {24'd0, xmitdataH}, 32'hA5);
    reqH = 4'b0000;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
